// File: rtl/obuf_drain_if.sv
// Output-buffer drain bus: start/status, memory read port and stream.
// The master side belongs to the drain engine.
interface obuf_drain_if #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int LEN_W          = 12
);
    logic                      start;
    logic [MEM_ADDR_WIDTH-1:0] base_addr;
    logic [LEN_W-1:0]          num_words;
    logic                      busy;
    logic                      done;
    logic                      mem_read_req;
    logic [MEM_ADDR_WIDTH-1:0] mem_read_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_read_data;
    logic                      m_valid;
    logic [MEM_DATA_WIDTH-1:0] m_data;
    logic                      m_last;
    logic                      m_ready;

    modport master (
        input  start, base_addr, num_words, mem_read_data, m_ready,
        output busy, done, mem_read_req, mem_read_addr,
        output m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, num_words, mem_read_data, m_ready,
        input  busy, done, mem_read_req, mem_read_addr,
        input  m_valid, m_data, m_last
    );
endinterface

// File: rtl/obuf_drain.sv
// Drains a window of the output-buffer memory into a valid/ready stream.
// Reads are throttled so a staging FIFO can always absorb returned data.
module obuf_drain #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int LEN_W          = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input logic         clk,
    input logic         reset,
    obuf_drain_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [LEN_W-1:0]          rd_left_q, rd_left_d;
    logic                      inflight_q, inflight_d;
    logic                      infl_last_q, infl_last_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [MEM_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                      fifo_last [FIFO_DEPTH];

    logic accept, push, pop, rd_req, last_hs;

    // Handshake qualifiers and read throttle
    always_comb begin
        accept  = bus.start && !busy_q && (state_q == IDLE);
        push    = inflight_q;
        pop     = (cnt_q != '0) && bus.m_ready;
        rd_req  = (state_q == READ) &&
                  ((cnt_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        last_hs = pop && fifo_last[rd_ptr_q];
    end

    // Next-state logic for the sequencer, read address and FIFO pointers
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        rd_left_d   = rd_left_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.num_words != '0) begin
                        state_d     = READ;
                        next_addr_d = bus.base_addr;
                        rd_left_d   = bus.num_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_req) begin
                    last_addr_d = next_addr_q;
                    next_addr_d = next_addr_q + MEM_ADDR_WIDTH'(1);
                    rd_left_d   = rd_left_q - LEN_W'(1);
                    if (rd_left_q == LEN_W'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d  = rd_req;
        infl_last_d = rd_req && (rd_left_q == LEN_W'(1));
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        // busy also covers the done cycle after the final handshake
        busy_d      = (state_d != IDLE) || last_hs;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            rd_left_q   <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
            rd_left_q   <= rd_left_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Capture returned read data one cycle after its request
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data[wr_ptr_q] <= bus.mem_read_data;
            fifo_last[wr_ptr_q] <= infl_last_q;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.mem_read_req  = rd_req;
    assign bus.mem_read_addr = rd_req ? next_addr_q : last_addr_q;
    assign bus.m_valid       = (cnt_q != '0);
    assign bus.m_data        = fifo_data[rd_ptr_q];
    assign bus.m_last        = (cnt_q != '0) && fifo_last[rd_ptr_q];
endmodule

// File: tb/tb_obuf_drain.sv
// Randomized bench for obuf_drain against an address/word-list model.
// Memory contents are random; expected stream is mem[base+i mod 2^AW].
module tb_obuf_drain;
    localparam int DW = 64;
    localparam int AW = 11;
    localparam int LW = 12;
    localparam int FD = 4;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obuf_drain_if #(
        .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .LEN_W(LW)
    ) bus ();

    obuf_drain #(
        .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW),
        .LEN_W(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [DW-1:0] mem [2**AW];

    // Memory port model: data one cycle after the request
    always @(posedge clk) begin
        if (bus.mem_read_req) bus.mem_read_data <= mem[bus.mem_read_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drain(input logic [AW-1:0] base, input int n,
                         input int mode, input bit dup, input int abort);
        int rd_cnt = 0;
        int popped = 0;
        int cyc = 0;
        int first_rd = -1;
        int last_rd = -1;
        bit hs_prev = 0;
        bit fin = 0;
        bit prev_stall = 0;
        bit rdy;
        bit v;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] ea;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_words = LW'(n);
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.start = dup && (cyc == 2);
            bus.base_addr = base ^ AW'('h155);
            bus.num_words = LW'(7);
            chk("done", bus.done, hs_prev || (n == 0 && cyc == 1));
            chk("busy", bus.busy, (n != 0) && !fin);
            if (bus.mem_read_req) begin
                chk("rd_in_range", rd_cnt < n, 1);
                ea = base + AW'(rd_cnt);
                chk("addr", bus.mem_read_addr, ea);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            chk("occupancy", (rd_cnt - popped) <= FD, 1);
            v = bus.m_valid;
            if (v) begin
                chk("pop_in_range", popped < n, 1);
                ea = base + AW'(popped);
                chk("data", bus.m_data, mem[ea]);
                chk("last", bus.m_last, popped == n - 1);
                if (prev_stall) chk("hold", bus.m_data, prev_data);
            end
            if (mode == 2 && cyc == 12) begin
                chk("stall_reads", rd_cnt, (n < FD) ? n : FD);
                chk("stall_valid", v, n > 0);
            end
            if (bus.done) fin = 1;
            else if (fin) break;
            if (abort > 0 && popped == abort) begin
                reset = 1'b1;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom % 2);
                default: rdy = (cyc >= 12);
            endcase
            bus.m_ready = rdy;
            hs_prev = v && rdy && bus.m_last;
            if (v && rdy) begin
                popped++;
                prev_stall = 0;
            end else begin
                prev_stall = v;
            end
            prev_data = bus.m_data;
        end
        chk("no_timeout", cyc < BUDGET, 1);
        if (abort == 0) begin
            chk("n_reads", rd_cnt, n);
            chk("n_words", popped, n);
            if (mode == 0 && n > 0) chk("back2back", last_rd - first_rd, n - 1);
        end else begin
            @(negedge clk);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_req", bus.mem_read_req, 0);
            chk("rst_addr", bus.mem_read_addr, 0);
            chk("rst_valid", bus.m_valid, 0);
            chk("rst_last", bus.m_last, 0);
            reset = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("post_rst_done", bus.done, 0);
                chk("post_rst_valid", bus.m_valid, 0);
            end
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = {$urandom, $urandom};
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.m_ready = 1'b0;
        bus.mem_read_data = '0;
        repeat (3) @(negedge clk);
        chk("init_busy", bus.busy, 0);
        chk("init_done", bus.done, 0);
        chk("init_req", bus.mem_read_req, 0);
        chk("init_addr", bus.mem_read_addr, 0);
        chk("init_valid", bus.m_valid, 0);
        chk("init_last", bus.m_last, 0);
        reset = 1'b0;
        @(negedge clk);
        drain(AW'('h010), 8, 0, 0, 0);
        drain(AW'('h020), 6, 2, 0, 0);
        drain(AW'('h7FE), 4, 0, 0, 0);
        drain(AW'('h100), 0, 0, 0, 0);
        drain(AW'('h200), 5, 0, 1, 0);
        drain(AW'('h280), 9, 1, 1, 0);
        drain(AW'('h300), 8, 0, 0, 3);
        drain(AW'('h050), 2, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drain(AW'($urandom), $urandom_range(0, 12),
                  $urandom_range(0, 2), 1'($urandom % 2), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
